// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard and pipeline-control unit for the 5-stage RV32I pipeline. It drives
// the stall (en) and flush (clr) controls of the IF/ID, ID/EX and EX/MEM
// pipeline registers and the EX-stage forwarding selects. It resolves
// load-use hazards, taken-branch redirects and multi-cycle data-memory waits.
// A memory-wait state machine with a saturating timeout counter aborts a
// data-memory access that never completes.
//
// Parameters:
//   MEM_TIMEOUT  max cycles spent in MEM_WAIT before abort (1..255)
//   TO_W         width of the timeout counter
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   rs1_d, rs2_d          ID-stage source registers
//   rs1_e, rs2_e, rd_e    EX-stage source / destination registers
//   load_e                EX instruction is a load
//   rd_m, regwrite_m      MEM-stage destination / write enable
//   rd_w, regwrite_w      WB-stage destination / write enable
//   pcsrc_e               EX branch/jump taken
//   dmem_req_m            MEM stage issues a data-memory access
//   dmem_ready            data memory completes the access this cycle
//   stall_f, stall_d      hold PC, hold IF/ID
//   flush_d, flush_e      clear IF/ID (NOP), clear ID/EX (bubble)
//   stall_em              hold ID/EX, EX/MEM, MEM/WB
//   forward_a_e/_b_e      00 regfile, 10 from MEM, 01 from WB
//   mem_abort             one-cycle pulse on memory timeout
//
// Optional build macro HAZARD_PERF_CNT_EN adds free-running 32-bit
// performance counters stall_cnt, flush_cnt and wait_cnt.
// ----------------------------------------------------------------------------
module hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned TO_W        = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] rs1_d,
   input  logic [4:0] rs2_d,
   input  logic [4:0] rs1_e,
   input  logic [4:0] rs2_e,
   input  logic [4:0] rd_e,
   input  logic       load_e,
   input  logic [4:0] rd_m,
   input  logic       regwrite_m,
   input  logic [4:0] rd_w,
   input  logic       regwrite_w,
   input  logic       pcsrc_e,
   input  logic       dmem_req_m,
   input  logic       dmem_ready,
   output logic       stall_f,
   output logic       stall_d,
   output logic       flush_d,
   output logic       flush_e,
   output logic       stall_em,
   output logic [1:0] forward_a_e,
   output logic [1:0] forward_b_e,
   output logic       mem_abort
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] stall_cnt,
   output logic [31:0] flush_cnt,
   output logic [31:0] wait_cnt
`endif
);

   typedef enum logic [1:0] {
      StRun     = 2'd0,
      StMemWait = 2'd1,
      StAbort   = 2'd2
   } state_e;

   localparam logic [TO_W-1:0] TimeoutVal = TO_W'(MEM_TIMEOUT);
   localparam logic [TO_W-1:0] CntOne     = TO_W'(1);

   state_e          state_q, state_d;
   logic [TO_W-1:0] cnt_q, cnt_d;

   logic       lw_stall;
   logic       wait_start;
   logic [1:0] fwd_a;
   logic [1:0] fwd_b;

   // MEM result is newer than WB, so it takes priority; x0 is never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic [4:0] rdm, input logic wm,
                                          input logic [4:0] rdw, input logic ww);
      if (wm && (rdm != 5'd0) && (rdm == rs)) begin
         return 2'b10;
      end else if (ww && (rdw != 5'd0) && (rdw == rs)) begin
         return 2'b01;
      end
      return 2'b00;
   endfunction

   always_comb begin
      fwd_a = fwd_sel(rs1_e, rd_m, regwrite_m, rd_w, regwrite_w);
      fwd_b = fwd_sel(rs2_e, rd_m, regwrite_m, rd_w, regwrite_w);
   end

   assign lw_stall   = load_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
   // A request that completes in its own cycle never causes a wait.
   assign wait_start = dmem_req_m && !dmem_ready;

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StRun;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and timeout counter
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StRun: begin
            if (wait_start) begin
               state_d = StMemWait;
               cnt_d   = CntOne;
            end
         end
         StMemWait: begin
            if (dmem_ready) begin
               state_d = StRun;
               cnt_d   = '0;
            end else if (cnt_q == TimeoutVal) begin
               state_d = StAbort;
            end else if (cnt_q < TimeoutVal) begin
               // Saturating: never wraps past the timeout value.
               cnt_d = cnt_q + CntOne;
            end
         end
         StAbort: begin
            state_d = StRun;
            cnt_d   = '0;
         end
         default: begin
            state_d = StRun;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs; everything is held at 0 while reset is high.
   always_comb begin
      stall_f     = 1'b0;
      stall_d     = 1'b0;
      flush_d     = 1'b0;
      flush_e     = 1'b0;
      stall_em    = 1'b0;
      forward_a_e = 2'b00;
      forward_b_e = 2'b00;
      mem_abort   = 1'b0;
      if (!reset) begin
         forward_a_e = fwd_a;
         forward_b_e = fwd_b;
         unique case (state_q)
            StRun: begin
               if (wait_start) begin
                  // Freeze the whole pipe; a taken branch stays parked in EX.
                  stall_f  = 1'b1;
                  stall_d  = 1'b1;
                  stall_em = 1'b1;
               end else begin
                  // With load-use and taken branch together, the flush wins at
                  // IF/ID; the PC mux takes the redirect from pcsrc_e.
                  stall_f = lw_stall;
                  stall_d = lw_stall;
                  flush_d = pcsrc_e;
                  flush_e = lw_stall || pcsrc_e;
               end
            end
            StMemWait: begin
               stall_f  = 1'b1;
               stall_d  = 1'b1;
               stall_em = 1'b1;
            end
            StAbort: begin
               mem_abort = 1'b1;
               flush_d   = 1'b1;
               flush_e   = 1'b1;
            end
            default: begin
               stall_f = 1'b0;
            end
         endcase
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_q, flush_cnt_q, wait_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         wait_cnt_q  <= '0;
      end else begin
         if ((state_q == StRun) && lw_stall) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         if (flush_e) begin
            flush_cnt_q <= flush_cnt_q + 32'd1;
         end
         if (state_q == StMemWait) begin
            wait_cnt_q <= wait_cnt_q + 32'd1;
         end
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
   assign wait_cnt  = wait_cnt_q;
`endif

endmodule
